// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants and update-window FSM encoding.
// Also used by the sync decoder.
package vga_pkg;

  localparam int unsigned CLK_DIV_DEF = 4;
  localparam int unsigned CNT_W       = 10;

  localparam int unsigned HD = 640;
  localparam int unsigned HF = 16;
  localparam int unsigned HB = 48;
  localparam int unsigned HR = 96;
  localparam int unsigned HT = HD + HF + HB + HR;

  localparam int unsigned VD = 480;
  localparam int unsigned VF = 10;
  localparam int unsigned VB = 33;
  localparam int unsigned VR = 2;
  localparam int unsigned VT = VD + VF + VB + VR;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } upd_state_e;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock by CLK_DIV (>= 2) into a registered one-clock pixel tick.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic pix_tick_o
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          tick_q;

  always_comb begin
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // The tick is registered from the next count so it lines up with div_cnt == CLK_DIV-1.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_d == DIV_LAST);
    end
  end

  assign pix_tick_o = tick_q;

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA scan timing plus vblank-only scene update windows for the game logic.
// Optional FRAME_COUNTER_EN adds a 16-bit frame_count_o output.
module vga_frame_scheduler #(
  parameter int unsigned CLK_DIV = vga_pkg::CLK_DIV_DEF,
  parameter int unsigned H_DISP  = vga_pkg::HD,
  parameter int unsigned H_FRONT = vga_pkg::HF,
  parameter int unsigned H_BACK  = vga_pkg::HB,
  parameter int unsigned H_RETR  = vga_pkg::HR,
  parameter int unsigned V_DISP  = vga_pkg::VD,
  parameter int unsigned V_FRONT = vga_pkg::VF,
  parameter int unsigned V_BACK  = vga_pkg::VB,
  parameter int unsigned V_RETR  = vga_pkg::VR
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic       pix_tick_o,
  output logic [9:0] h_count_o,
  output logic [9:0] v_count_o,
  output logic       line_start_o,
  output logic       frame_start_o,
  output logic       in_vblank_o,
  input  logic       upd_req_i,
  output logic       upd_grant_o,
  input  logic       upd_done_i,
  output logic       overrun_o
`ifdef FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_count_o
`endif
);

  import vga_pkg::*;

  localparam int unsigned H_TOT = H_DISP + H_FRONT + H_BACK + H_RETR;
  localparam int unsigned V_TOT = V_DISP + V_FRONT + V_BACK + V_RETR;
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] V_DISP_C = 10'(V_DISP);

  logic       pix_tick_s;
  logic [9:0] h_q;
  logic [9:0] h_d;
  logic [9:0] v_q;
  logic [9:0] v_d;
  logic       line_q;
  logic       frame_q;
  logic       vblank_q;
  logic       win_open_s;
  upd_state_e state_q;
  logic       grant_q;
  logic       overrun_q;
  logic       granted_this_frame_q;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .pix_tick_o (pix_tick_s)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_tick_s) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end else begin
      h_d = h_q;
    end
  end

  // Closes on the last line so the final line before active video stays untouched.
  assign win_open_s = (v_q >= V_DISP_C) && (v_q < V_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      line_q   <= pix_tick_s && (h_d == 10'd0);
      frame_q  <= pix_tick_s && (h_d == 10'd0) && (v_d == 10'd0);
      vblank_q <= (v_d >= V_DISP_C);
    end
  end

  // Done wins over a simultaneous window close, so overrun only fires without upd_done.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q              <= ST_IDLE;
      grant_q              <= 1'b0;
      overrun_q            <= 1'b0;
      granted_this_frame_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_q) begin
        granted_this_frame_q <= 1'b0;
      end else begin
        granted_this_frame_q <= granted_this_frame_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (upd_req_i && win_open_s && !granted_this_frame_q) begin
            state_q              <= ST_GRANT;
            grant_q              <= 1'b1;
            granted_this_frame_q <= 1'b1;
          end else begin
            grant_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (upd_done_i) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
          end else if (!win_open_s) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            overrun_q <= 1'b1;
          end else begin
            grant_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q;

  // Updates alongside frame_start so the new count is visible with the pulse.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_cnt_q <= 16'd0;
    end else if (pix_tick_s && (h_d == 10'd0) && (v_d == 10'd0)) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_q <= frame_cnt_q;
    end
  end

  assign frame_count_o = frame_cnt_q;
`else
  // No frame counter in this build.
`endif

  assign pix_tick_o    = pix_tick_s;
  assign h_count_o     = h_q;
  assign v_count_o     = v_q;
  assign line_start_o  = line_q;
  assign frame_start_o = frame_q;
  assign in_vblank_o   = vblank_q;
  assign upd_grant_o   = grant_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomized bench for vga_frame_scheduler against a tick-count reference model, scaled timing.
// Define FRAME_COUNTER_EN to also check frame_count_o, including a forced wrap.
module tb_vga_frame_scheduler;

  localparam int CD = 4;
  localparam int HD = 8;
  localparam int HF = 2;
  localparam int HB = 3;
  localparam int HR = 2;
  localparam int VD = 6;
  localparam int VF = 1;
  localparam int VB = 2;
  localparam int VR = 1;
  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int NCYC = 14 * HT * VT * CD;

  logic       clk = 1'b0;
  logic       reset;
  logic       upd_req;
  logic       upd_done;
  logic       pix_tick;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       line_start;
  logic       frame_start;
  logic       in_vblank;
  logic       upd_grant;
  logic       overrun;
`ifdef FRAME_COUNTER_EN
  logic [15:0] frame_count;
`endif

  vga_frame_scheduler #(
    .CLK_DIV (CD),
    .H_DISP  (HD), .H_FRONT (HF), .H_BACK (HB), .H_RETR (HR),
    .V_DISP  (VD), .V_FRONT (VF), .V_BACK (VB), .V_RETR (VR)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .pix_tick_o    (pix_tick),
    .h_count_o     (h_count),
    .v_count_o     (v_count),
    .line_start_o  (line_start),
    .frame_start_o (frame_start),
    .in_vblank_o   (in_vblank),
    .upd_req_i     (upd_req),
    .upd_grant_o   (upd_grant),
    .upd_done_i    (upd_done),
    .overrun_o     (overrun)
`ifdef FRAME_COUNTER_EN
    ,
    .frame_count_o (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int c     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, c);
    end
  endtask

  // Reference timing: everything follows from clocks elapsed since reset release.
  function automatic int f_ticks(input int cc); return cc / CD; endfunction
  function automatic int f_h(input int cc); return f_ticks(cc) % HT; endfunction
  function automatic int f_v(input int cc); return (f_ticks(cc) / HT) % VT; endfunction
  function automatic bit f_tick(input int cc); return (cc % CD) == CD - 1; endfunction
  function automatic bit f_ls(input int cc); return cc > 0 && (cc % CD) == 0 && f_h(cc) == 0; endfunction
  function automatic bit f_fs(input int cc); return f_ls(cc) && f_v(cc) == 0; endfunction

  bit m_grant = 1'b0;
  bit m_gtf   = 1'b0;
  bit m_ovr   = 1'b0;
  int m_fc    = 0;
  int m_ovr_cnt = 0;
  int m_gnt_cnt = 0;
  int d_ovr_cnt = 0;
  int d_gnt_cnt = 0;
  bit prev_grant = 1'b0;

  initial begin
    int  frames;
    int  mode;
    bit  did_rst;
    bit  did_force;
    bit  rst_nx;
    bit  win;
    bit  g;
    bit  gtf;
    bit  ovr_nx;
    frames = 0; mode = 0; did_rst = 1'b0; did_force = 1'b0;
    reset = 1'b1; upd_req = 1'b0; upd_done = 1'b0;
    repeat (5) @(posedge clk);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      check_eq("pix_tick", pix_tick, f_tick(c));
      check_eq("h_count", h_count, f_h(c));
      check_eq("v_count", v_count, f_v(c));
      check_eq("line_start", line_start, f_ls(c));
      check_eq("frame_start", frame_start, f_fs(c));
      check_eq("in_vblank", in_vblank, f_v(c) >= VD);
      check_eq("upd_grant", upd_grant, m_grant);
      check_eq("overrun", overrun, m_ovr);
`ifdef FRAME_COUNTER_EN
      check_eq("frame_count", frame_count, m_fc);
      if (did_force) release dut.frame_cnt_q;
      if (!did_force && frames == 6 && f_v(c) == 2 && f_ls(c)) begin
        force dut.frame_cnt_q = 16'hFFFF;
        m_fc = 65535;
        did_force = 1'b1;
      end
`endif
      if (overrun === 1'b1) d_ovr_cnt++;
      if (upd_grant === 1'b1 && !prev_grant) d_gnt_cnt++;
      prev_grant = (upd_grant === 1'b1);

      if (f_fs(c)) begin
        frames++;
        mode = $urandom_range(0, 2);
      end
      rst_nx = !did_rst && frames >= 4 && m_grant && ($urandom_range(0, 3) == 0);
      if (rst_nx) did_rst = 1'b1;
      if (mode == 1) begin
        upd_req = 1'b1;
      end else if (!upd_req) begin
        upd_req = ($urandom_range(0, 7) == 0);
      end else if (m_grant && $urandom_range(0, 3) == 0) begin
        upd_req = 1'b0;
      end
      case (mode)
        0:       upd_done = ($urandom_range(0, 5) == 0);
        2:       upd_done = (f_v(c) == VT - 1) && f_ls(c);
        default: upd_done = 1'b0;
      endcase
      reset = rst_nx;

      if (rst_nx) begin
        c = 0; m_grant = 1'b0; m_gtf = 1'b0; m_ovr = 1'b0; m_fc = 0;
      end else begin
        win = f_v(c) >= VD && f_v(c) < VT - 1;
        g = m_grant; gtf = m_gtf; ovr_nx = 1'b0;
        if (f_fs(c)) gtf = 1'b0;
        if (m_grant) begin
          if (upd_done) g = 1'b0;
          else if (!win) begin g = 1'b0; ovr_nx = 1'b1; end
        end else if (upd_req && win && !m_gtf) begin
          g = 1'b1; gtf = 1'b1; m_gnt_cnt++;
        end
        m_grant = g; m_gtf = gtf; m_ovr = ovr_nx;
        if (ovr_nx) m_ovr_cnt++;
        c++;
        if (f_fs(c)) m_fc = (m_fc + 1) % 65536;
      end
    end
    check_eq("overrun_count", d_ovr_cnt, m_ovr_cnt);
    check_eq("grant_count", d_gnt_cnt, m_gnt_cnt);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
